// File: rtl/case4_pkg.sv
// Shared constants, types and width helpers for the case-4 datapath and its sequencer.
package case4_pkg;

  localparam int CASE4_J        = 4;
  localparam int CASE4_A        = 4;
  localparam int CASE4_I        = 7;
  localparam int CASE4_PIPE_LAT = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } case4_seq_state_t;

  // One spare bit so a counter can hold its own loop count without overflow.
  function automatic int idx_width(input int n);
    return $clog2(n) + 1;
  endfunction

  localparam int CASE4_J_WIDTH = idx_width(CASE4_J);
  localparam int CASE4_A_WIDTH = idx_width(CASE4_A);
  localparam int CASE4_I_WIDTH = idx_width(CASE4_I);

endpackage

// File: rtl/case4_delay_line.sv
// Fixed-depth shift register that carries write-back tags alongside the datapath pipeline.
module case4_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
    end else begin
      stage[0] <= din;
      for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/case4_loop_sequencer.sv
// Walks the J x A x I iteration space for the case-4 datapath and aligns per-(j,a) write-back.
//   state    | meaning
//   ST_IDLE  | waiting for start, outputs quiet
//   ST_RUN   | issuing tuples, stepping on dp_ready
//   ST_DRAIN | all tuples issued, waiting for final write-back
//   ST_DONE  | one-cycle done pulse
module case4_loop_sequencer
  import case4_pkg::*;
#(
  parameter  int J        = CASE4_J,
  parameter  int A        = CASE4_A,
  parameter  int I        = CASE4_I,
  parameter  int PIPE_LAT = CASE4_PIPE_LAT,
  localparam int J_WIDTH  = idx_width(J),
  localparam int A_WIDTH  = idx_width(A),
  localparam int I_WIDTH  = idx_width(I)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               dp_ready,
  output logic               busy,
  output logic               issue_valid,
  output logic [J_WIDTH-1:0] j_idx,
  output logic [A_WIDTH-1:0] a_idx,
  output logic [I_WIDTH-1:0] i_idx,
  output logic               acc_clr,
  output logic               acc_last,
  output logic               wb_valid,
  output logic [J_WIDTH-1:0] wb_j,
  output logic [A_WIDTH-1:0] wb_a,
  output logic               done
);

  localparam int TAG_W = 1 + J_WIDTH + A_WIDTH;

  case4_seq_state_t state;

  logic             accept;
  logic             i_wrap;
  logic             a_wrap;
  logic             j_last;
  logic             last_tuple;
  logic             final_wb;
  logic [TAG_W-1:0] tag_in;
  logic [TAG_W-1:0] tag_out;

  assign issue_valid = (state == ST_RUN);
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);
  assign accept      = issue_valid & dp_ready;

  assign i_wrap     = (i_idx == I_WIDTH'(I - 1));
  assign a_wrap     = (a_idx == A_WIDTH'(A - 1));
  assign j_last     = (j_idx == J_WIDTH'(J - 1));
  assign last_tuple = i_wrap & a_wrap & j_last;

  assign acc_clr  = issue_valid & (i_idx == '0);
  assign acc_last = issue_valid & i_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      j_idx <= '0;
      a_idx <= '0;
      i_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            j_idx <= '0;
            a_idx <= '0;
            i_idx <= '0;
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (i_wrap) begin
              i_idx <= '0;
              if (a_wrap) begin
                a_idx <= '0;
                j_idx <= j_last ? '0 : j_idx + 1'b1;
              end else begin
                a_idx <= a_idx + 1'b1;
              end
            end else begin
              i_idx <= i_idx + 1'b1;
            end
            if (last_tuple) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (final_wb) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Only accepted last-of-accumulation issues enter the tag pipe; everything else shifts zeros.
  assign tag_in = (accept & i_wrap) ? {1'b1, j_idx, a_idx} : '0;

  case4_delay_line #(
    .WIDTH(TAG_W),
    .DEPTH(PIPE_LAT)
  ) u_wb_delay (
    .clk (clk),
    .rst (rst),
    .din (tag_in),
    .dout(tag_out)
  );

  assign {wb_valid, wb_j, wb_a} = tag_out;

  // With short I or long PIPE_LAT, earlier write-backs can still land during DRAIN.
  assign final_wb = wb_valid & (wb_j == J_WIDTH'(J - 1)) & (wb_a == A_WIDTH'(A - 1));

endmodule

// File: tb/tb_case4_loop_sequencer.sv
// Bench for case4_loop_sequencer: schedule-based reference model for the default sizes, table for J=A=I=PIPE_LAT=1.
module tb_case4_loop_sequencer;
  import case4_pkg::*;

  localparam int J = 4, A = 4, I = 7, P = 3;
  localparam int NTOT = J * A * I;
  localparam int JW = 3, AW = 3, IW = 4;
  localparam int MAXT = 520;

  typedef struct packed {
    logic          busy;
    logic          iv;
    logic [JW-1:0] j;
    logic [AW-1:0] a;
    logic [IW-1:0] i;
    logic          clr;
    logic          last;
    logic          wbv;
    logic [JW-1:0] wbj;
    logic [AW-1:0] wba;
    logic          done;
  } outs_t;

  typedef struct packed {
    logic       start;
    logic       rdy;
    logic [5:0] flags;  // busy, issue_valid, acc_clr, acc_last, wb_valid, done
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, dp_ready = 1'b1;
  logic start2 = 1'b0, dp_ready2 = 1'b1;

  logic busy, issue_valid, acc_clr, acc_last, wb_valid, done;
  logic [JW-1:0] j_idx, wb_j;
  logic [AW-1:0] a_idx, wb_a;
  logic [IW-1:0] i_idx;

  logic busy2, iv2, clr2, last2, wbv2, done2;
  logic [0:0] j2, a2, i2, wbj2, wba2;

  int n_checks = 0;
  int n_pass = 0;

  logic  st_a  [MAXT];
  logic  rdy_a [MAXT];
  outs_t expv  [MAXT];
  vec_t  tbl   [16];

  always #5 clk = ~clk;

  case4_loop_sequencer u_dut (
    .clk(clk), .rst(rst), .start(start), .dp_ready(dp_ready),
    .busy(busy), .issue_valid(issue_valid), .j_idx(j_idx), .a_idx(a_idx), .i_idx(i_idx),
    .acc_clr(acc_clr), .acc_last(acc_last), .wb_valid(wb_valid), .wb_j(wb_j), .wb_a(wb_a),
    .done(done)
  );

  case4_loop_sequencer #(.J(1), .A(1), .I(1), .PIPE_LAT(1)) u_dut_min (
    .clk(clk), .rst(rst), .start(start2), .dp_ready(dp_ready2),
    .busy(busy2), .issue_valid(iv2), .j_idx(j2), .a_idx(a2), .i_idx(i2),
    .acc_clr(clr2), .acc_last(last2), .wb_valid(wbv2), .wb_j(wbj2), .wb_a(wba2),
    .done(done2)
  );

  function automatic outs_t actual();
    outs_t o;
    o = '{busy, issue_valid, j_idx, a_idx, i_idx, acc_clr, acc_last, wb_valid, wb_j, wb_a, done};
    return o;
  endfunction

  task automatic check(input string name, input int t, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, t, act, exp);
  endtask

  task automatic clear_stim();
    for (int t = 0; t < MAXT; t++) begin
      st_a[t]  = 1'b0;
      rdy_a[t] = 1'b1;
    end
  endtask

  // Schedule each accepted pass: tuple n = n-th point of the j/a/i walk, held until dp_ready.
  task automatic build_model(input int T);
    int t, c, last_wb, jj, aa, ii;
    bit acc;
    for (int k = 0; k < MAXT; k++) expv[k] = '0;
    t = 0;
    while (t < T) begin
      if (st_a[t]) begin
        c = t + 1;
        last_wb = c;
        for (int n = 0; n < NTOT; n++) begin
          jj = n / (A * I);
          aa = (n / I) % A;
          ii = n % I;
          acc = 1'b0;
          while (!acc) begin
            if (c < MAXT) begin
              expv[c].busy = 1'b1;
              expv[c].iv   = 1'b1;
              expv[c].j    = JW'(jj);
              expv[c].a    = AW'(aa);
              expv[c].i    = IW'(ii);
              expv[c].clr  = (ii == 0);
              expv[c].last = (ii == I - 1);
            end
            acc = (c < T) ? rdy_a[c] : 1'b1;
            c++;
          end
          if (ii == I - 1) begin
            last_wb = c - 1 + P;
            if (last_wb < MAXT) begin
              expv[last_wb].wbv = 1'b1;
              expv[last_wb].wbj = JW'(jj);
              expv[last_wb].wba = AW'(aa);
            end
          end
        end
        for (int k = c; k <= last_wb + 1 && k < MAXT; k++) expv[k].busy = 1'b1;
        if (last_wb + 1 < MAXT) expv[last_wb + 1].done = 1'b1;
        t = last_wb + 2;
      end else begin
        t++;
      end
    end
  endtask

  task automatic run_scenario(input string name, input int T);
    build_model(T);
    for (int t = 0; t < T; t++) begin
      @(posedge clk); #1;
      start    = st_a[t];
      dp_ready = rdy_a[t];
      @(negedge clk);
      check(name, t, 64'(actual()), 64'(expv[t]));
    end
    start    = 1'b0;
    dp_ready = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 6'b000000};
    tbl[1]  = '{1'b0, 1'b1, 6'b111100};
    tbl[2]  = '{1'b0, 1'b1, 6'b100010};
    tbl[3]  = '{1'b0, 1'b1, 6'b100001};
    tbl[4]  = '{1'b0, 1'b1, 6'b000000};
    tbl[5]  = '{1'b1, 1'b0, 6'b000000};
    tbl[6]  = '{1'b0, 1'b0, 6'b111100};
    tbl[7]  = '{1'b0, 1'b1, 6'b111100};
    tbl[8]  = '{1'b0, 1'b1, 6'b100010};
    tbl[9]  = '{1'b1, 1'b1, 6'b100001};
    tbl[10] = '{1'b0, 1'b1, 6'b000000};
    tbl[11] = '{1'b1, 1'b1, 6'b000000};
    tbl[12] = '{1'b0, 1'b1, 6'b111100};
    tbl[13] = '{1'b0, 1'b1, 6'b100010};
    tbl[14] = '{1'b0, 1'b1, 6'b100001};
    tbl[15] = '{1'b0, 1'b1, 6'b000000};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", 0, 64'(actual()), 64'(0));
    check("reset_state_min", 0, 64'({busy2, iv2, clr2, last2, wbv2, done2}), 64'(0));
    rst = 1'b0;

    for (int t = 0; t < 16; t++) begin
      @(posedge clk); #1;
      start2    = tbl[t].start;
      dp_ready2 = tbl[t].rdy;
      @(negedge clk);
      check("degenerate", t,
            64'({busy2, iv2, clr2, last2, wbv2, done2, j2, a2, i2, wbj2, wba2}),
            64'({tbl[t].flags, 5'b00000}));
    end
    start2 = 1'b0;

    clear_stim(); st_a[0] = 1'b1;
    run_scenario("basic", 120);

    clear_stim(); st_a[0] = 1'b1;
    rdy_a[5] = 1'b0; rdy_a[6] = 1'b0; rdy_a[7] = 1'b0; rdy_a[50] = 1'b0;
    run_scenario("backpressure", 124);

    clear_stim(); st_a[0] = 1'b1; st_a[30] = 1'b1; st_a[116] = 1'b1;
    run_scenario("start_busy", 122);

    clear_stim(); st_a[0] = 1'b1; st_a[117] = 1'b1;
    run_scenario("back_to_back", 238);

    clear_stim(); st_a[0] = 1'b1;
    run_scenario("rst_pre", 60);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_async", 60, 64'(actual()), 64'(0));
    @(negedge clk);
    check("rst_hold", 60, 64'(actual()), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    clear_stim();
    run_scenario("rst_quiet", 12);
    clear_stim(); st_a[0] = 1'b1;
    run_scenario("rst_rerun", 120);

    clear_stim();
    st_a[0] = 1'b1;
    for (int t = 0; t < 500; t++) begin
      rdy_a[t] = ($urandom_range(3) != 0);
      if (t > 0 && t < 180) st_a[t] = ($urandom_range(19) == 0);
    end
    run_scenario("random", 500);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/case4_loop_sequencer.md
# case4_loop_sequencer

Sequencer that drives the case-4 fixed-point datapath through its full J×A×I iteration space after a single `start` pulse. It issues one index tuple per accepted cycle and marks accumulator clear and last points. It tracks the datapath's fixed pipeline latency so that per-(j,a) write-back strobes line up with results, and it reports completion with a `done` pulse. It sits between the top-level control (`start`) and the case-4 compute/memory datapath, replacing ad-hoc counters in the wrapper.

## Interface
- `J`, 4, outer loop count (users); must be ≥1
- `A`, 4, middle loop count (antennas); must be ≥1
- `I`, 7, inner loop count (iterations, accumulated); must be ≥1
- `PIPE_LAT`, 3, datapath latency in cycles from issue to result; must be ≥1
- Derived widths: J_WIDTH=$clog2(J)+1, A_WIDTH=$clog2(A)+1, I_WIDTH=$clog2(I)+1
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a pass; sampled only in IDLE
- `dp_ready`  in  1  datapath can accept an issue this cycle
- `busy`  out  1  high from the cycle after start acceptance through the `done` cycle
- `issue_valid`  out  1  index tuple valid
- `j_idx`  out  J_WIDTH  outer index
- `a_idx`  out  A_WIDTH  middle index
- `i_idx`  out  I_WIDTH  inner index
- `acc_clr`  out  1  issue_valid & (i_idx==0)
- `acc_last`  out  1  issue_valid & (i_idx==I-1)
- `wb_valid`  out  1  write-back strobe for one (j,a) result
- `wb_j`  out  J_WIDTH  j of the result being written back
- `wb_a`  out  A_WIDTH  a of the result being written back
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: outputs idle. start=1 → RUN, indices cleared to 0.
- RUN: issue_valid=1. An issue is accepted in a cycle with issue_valid & dp_ready. On acceptance the indices step with i innermost, then a, then j (i wraps I-1→0 and carries into a; a wraps A-1→0 and carries into j). dp_ready=0 holds all indices and flags stable. Acceptance of (J-1,A-1,I-1) → DRAIN, and issue_valid drops the next cycle.
- DRAIN: waits until the write-back for the final tuple has been emitted, then → DONE.
- DONE: done=1 for one cycle → IDLE.
- Total accepted issues per pass: J·A·I (112 at defaults). Total wb_valid pulses: J·A (16).
- The write-back path is a PIPE_LAT-deep shift of {acc_last accepted, j_idx, a_idx}. It is not stalled by dp_ready.
- start while busy is ignored; there is no queuing.
- Reset: asynchronous. All outputs go to 0 and the state to IDLE, including in the middle of a pass. The delay line is cleared, so no stale wb_valid appears after release.

## Timing
- Cycle 0: start sampled in IDLE. Cycle 1: busy=1, issue_valid=1 with (0,0,0) and acc_clr=1.
- With dp_ready held at 1: issues in cycles 1..112. The accepted issue in cycle k with acc_last=1 produces wb_valid in cycle k+PIPE_LAT.
- Defaults: last issue in cycle 112, last wb_valid in cycle 115, done in cycle 116, busy low and IDLE from cycle 117.
- Each dp_ready=0 cycle in RUN delays every later event by one cycle.
- A start asserted in the same cycle as done is ignored. A new start is accepted from the first IDLE cycle.

## Structure
- Shared package `case4_pkg`: default J/A/I/PIPE_LAT constants, state enum `case4_seq_state_t`, and width localparam functions, all reused by the wrapper and the datapath.
- Sub-module `case4_delay_line` (parameters WIDTH, DEPTH; async active-high clear) implements the write-back alignment.
- The counters and FSM stay in the top module.

## Test plan
- Basic pass, defaults, dp_ready=1, start in cycle 0 → 112 issues in cycles 1..112 in j/a/i order, 16 wb_valid pulses in the cycles following each (k+3) last-issue cycle, done in cycle 116.
- Backpressure: dp_ready low in cycles 5–7 and 50 → indices frozen during the stall, done in cycle 120, no tuple skipped or repeated.
- Reset mid-pass: rst asserted in cycle 60 → all outputs 0 immediately. After release, no wb_valid or done appears; a fresh start repeats the basic pass exactly.
- Start while busy: extra start pulses in cycles 30 and 116 → ignored, single pass, one done.
- Degenerate sizes: J=1, A=1, I=1, PIPE_LAT=1 → one issue with acc_clr=acc_last=1 in cycle 1, wb_valid in cycle 2, done in cycle 3.
- Back-to-back: start in cycle 117 → second pass identical to the first, offset by 117 cycles.
